mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Moore-style sequencing controller for the multi-cycle variant of the 32-bit MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles, and handshakes with a single shared instruction/data memory via MemReady.
- Drives all datapath enables and muxes and produces the PC enable, using the ALU Zero flag.
- Keeps a retired-instruction counter for bring-up.

Parameters:
CNT_W, 32, width of retired-instruction counter InstrCount

Ports:
CLK  input  1  rising-edge clock
Reset_L  input  1  asynchronous, active-low reset
Opcode  input  6  IR[31:26], valid from the cycle after IRWrite
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current read/write this cycle
PCEn  output  1  PC register load enable
IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR and MDR
RegDst  output  1  1 = rd, 0 = rt
MemtoReg  output  1  1 = MDR to register file
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = A register
ALUSrcB  output  2  00 = B, 01 = 4, 10 = SignExtImm, 11 = SignExtImm<<2
SignExtend  output  1  1 = sign-extend immediate, 0 = zero-extend
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUOp  output  4  ALU operation code
Retire  output  1  one-cycle pulse when an instruction completes
IllegalOp  output  1  one-cycle pulse on an unsupported opcode
InstrCount  output  CNT_W  retired-instruction count
State  output  4  current state, for debug

Behaviour:
- Reset_L low, asynchronously:
  - State = IDLE; OpReg = 0; InstrCount = 0.
  - All outputs 0, including ALUOp = NOP 4'b0000.
- Reset mid-instruction abandons the instruction; no partial writes after reset asserts.
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12. Codes 13-15 go to FETCH.
- Outputs not listed for a state are 0.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD 4'b0111, PCSource=00.
  - Holds while MemReady=0.
  - In the MemReady=1 cycle: IRWrite=1 and PCEn=1; next state DECODE.
- DECODE:
  - Latches OpReg <= Opcode. ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut).
  - Next state by Opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 001000..001110 -> I_EXEC
    - 000100 or 000101 -> BRANCH
    - 000010 -> JUMP
    - anything else -> FETCH, with IllegalOp=1 and Retire=1 this cycle.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE 4'b1111.
- R_WB: RegDst=1, RegWrite=1, Retire=1.
- I_EXEC:
  - ALUSrcA=1, ALUSrcB=10.
  - ALUOp: 001000 ADD 0111, 001001 ADDU 0001, 001010 SLT 1010, 001011 SLTU 1011, 001100 AND 0100, 001101 OR 0101, 001110 XOR 0110.
  - SignExtend=1 for 001000..001011, 0 for 001100..001110.
- I_WB: RegDst=0, RegWrite=1, Retire=1, SignExtend held from I_EXEC.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, SignExtend=1, ALUOp=LWSW 4'b1110. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Holds until MemReady; IRWrite stays 0; next state MEM_WB.
- MEM_WB: MemtoReg=1, RegWrite=1, RegDst=0, Retire=1.
- MEM_WR: MemWrite=1, IorD=1. Holds until MemReady; Retire=1 in the MemReady cycle; next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=BE 4'b1000, PCSource=01, Retire=1.
  - PCEn = Zero XOR OpReg[0] (beq takes on Zero=1, bne on Zero=0).
- JUMP: PCSource=10, PCEn=1, Retire=1.
- All Retire states -> FETCH.
- Latency with MemReady always 1:
  - R / I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch / jump: 3 cycles
- Each MemReady=0 cycle adds one cycle.
- InstrCount increments by 1 on every Retire edge and wraps modulo 2^CNT_W.
- MemRead and MemWrite are never asserted together.
- PCEn and RegWrite are never asserted outside the states listed above.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding constants
  - opcode constants
  - ALUOp codes: NOP, ADDU, SUB, SUBU, AND, OR, XOR, ADD, BE, SLT, SLTU, LWSW, RTYPE
  - ALUSrcB and PCSource encodings
- Sub-module mips_iop_decode: combinational OpReg -> {ALUOp, SignExtend} for I-type. Instantiated once.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 -> 1 IDLE cycle, then FETCH with MemRead=1, IorD=0, PCEn=1, IRWrite=1; all outputs 0 during reset.
- Opcode 000000, MemReady=1 -> states 1,2,7,8; RegWrite=1 with RegDst=1 in cycle 4; Retire pulses once; InstrCount 0->1.
- lw (100011) with MemReady low 2 cycles in FETCH and 2 in MEM_RD -> FETCH 3 cycles, MEM_RD 3 cycles, total 9 cycles; MemtoReg=1 and RegWrite=1 only in MEM_WB.
- beq with Zero=1 -> PCEn=1; beq with Zero=0 -> PCEn=0; bne (000101) with Zero=0 -> PCEn=1; PCSource=01 in all three cases.
- andi (001100) -> ALUOp=0100 and SignExtend=0; slti (001010) -> ALUOp=1010 and SignExtend=1; opcode 111111 -> IllegalOp pulse in DECODE, then FETCH, and InstrCount increments.
- Reset_L dropped during MEM_WR with MemReady=0 -> MemWrite drops immediately (asynchronous); state returns to IDLE, then FETCH; InstrCount = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller:
// FSM state codes, supported opcodes, ALU operation codes and the
// ALUSrcB / PCSource mux selects. Also an I-type opcode range helper.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_NOP   = 4'b0000;
  localparam logic [3:0] ALU_ADDU  = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_SUBU  = 4'b0011;
  localparam logic [3:0] ALU_AND   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0110;
  localparam logic [3:0] ALU_ADD   = 4'b0111;
  localparam logic [3:0] ALU_BE    = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_LWSW  = 4'b1110;
  localparam logic [3:0] ALU_RTYPE = 4'b1111;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the contiguous immediate-ALU opcode range addi..xori.
  function automatic logic is_iop(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_XORI);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the sequencing controller and the datapath/memory.
// master: controller side (drives enables/selects, observes Opcode, Zero,
//         MemReady). slave: datapath side.
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCEn;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             SignExtend;
  logic [1:0]       PCSource;
  logic [3:0]       ALUOp;
  logic             Retire;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;
  logic [3:0]       State;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, SignExtend, PCSource, ALUOp,
           Retire, IllegalOp, InstrCount, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, SignExtend, PCSource, ALUOp,
           Retire, IllegalOp, InstrCount, State
  );
endinterface

// File: rtl/mips_multicycle_ctrl_iop_decode.sv
// Immediate-ALU opcode decoder: latched opcode -> ALU operation and
// immediate extension mode. Unsupported codes give NOP / zero-extend.
// Ports: op_i (opcode), alu_op_o (ALU code), sign_ext_o (1 = sign-extend).
module mips_iop_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  output logic [3:0] alu_op_o,
  output logic       sign_ext_o
);

  // Opcode table lookup.
  always_comb begin
    alu_op_o   = ALU_NOP;
    sign_ext_o = 1'b0;
    case (op_i)
      OP_ADDI:  begin alu_op_o = ALU_ADD;  sign_ext_o = 1'b1; end
      OP_ADDIU: begin alu_op_o = ALU_ADDU; sign_ext_o = 1'b1; end
      OP_SLTI:  begin alu_op_o = ALU_SLT;  sign_ext_o = 1'b1; end
      OP_SLTIU: begin alu_op_o = ALU_SLTU; sign_ext_o = 1'b1; end
      OP_ANDI:  begin alu_op_o = ALU_AND;  sign_ext_o = 1'b0; end
      OP_ORI:   begin alu_op_o = ALU_OR;   sign_ext_o = 1'b0; end
      OP_XORI:  begin alu_op_o = ALU_XOR;  sign_ext_o = 1'b0; end
      default:  begin alu_op_o = ALU_NOP;  sign_ext_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style sequencing controller for the multi-cycle MIPS datapath.
// Ports: CLK, Reset_L (async active-low), bus (master modport): Opcode,
// Zero, MemReady in; datapath enables/selects, Retire/IllegalOp pulses,
// InstrCount (retired count, wraps) and State (debug) out.
// Outputs decode from the current state (plus MemReady/Zero where an
// action must coincide with memory completion or the branch outcome), so
// asserting Reset_L low drops every output at once.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  CLK,
  input logic                  Reset_L,
  mips_multicycle_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [5:0]       opreg_q, opreg_d;
  logic [CNT_W-1:0] count_q;

  logic       pcen_s, iord_s, mem_read_s, mem_write_s, ir_write_s;
  logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, pc_source_s;
  logic       sign_ext_s, retire_s, illegal_s;
  logic [3:0] alu_op_s;
  logic [3:0] iop_alu_op_s;
  logic       iop_sign_ext_s;

  mips_iop_decode u_iop_decode (
    .op_i       (opreg_q),
    .alu_op_o   (iop_alu_op_s),
    .sign_ext_o (iop_sign_ext_s)
  );

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      opreg_q <= 6'd0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      opreg_q <= opreg_d;
      if (retire_s) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_q <= count_q;
      end
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d      = state_q;
    opreg_d      = opreg_q;
    pcen_s       = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = ALUSRCB_B;
    sign_ext_s   = 1'b0;
    pc_source_s  = PCSRC_ALU;
    alu_op_s     = ALU_NOP;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read.
        mem_read_s  = 1'b1;
        alu_src_b_s = ALUSRCB_FOUR;
        alu_op_s    = ALU_ADD;
        pc_source_s = PCSRC_ALU;
        if (bus.MemReady) begin
          ir_write_s = 1'b1;
          pcen_s     = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        opreg_d     = bus.Opcode;
        alu_src_b_s = ALUSRCB_IMM_SH2;
        alu_op_s    = ALU_ADD;
        if (is_iop(bus.Opcode)) begin
          state_d = S_I_EXEC;
        end else begin
          case (bus.Opcode)
            OP_RTYPE:      state_d = S_R_EXEC;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:          state_d = S_JUMP;
            default: begin
              illegal_s = 1'b1;
              retire_s  = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUSRCB_IMM;
        sign_ext_s  = 1'b1;
        alu_op_s    = ALU_LWSW;
        if (opreg_q == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (bus.MemReady) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
        retire_s     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (bus.MemReady) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUSRCB_B;
        alu_op_s    = ALU_RTYPE;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUSRCB_IMM;
        alu_op_s    = iop_alu_op_s;
        sign_ext_s  = iop_sign_ext_s;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        // Extension mode held so the immediate path stays stable on write.
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        sign_ext_s  = iop_sign_ext_s;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // OpReg[0] distinguishes bne (1) from beq (0).
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUSRCB_B;
        alu_op_s    = ALU_BE;
        pc_source_s = PCSRC_ALUOUT;
        pcen_s      = bus.Zero ^ opreg_q[0];
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_s = PCSRC_JUMP;
        pcen_s      = 1'b1;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.PCEn       = pcen_s;
  assign bus.IorD       = iord_s;
  assign bus.MemRead    = mem_read_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.IRWrite    = ir_write_s;
  assign bus.RegDst     = reg_dst_s;
  assign bus.MemtoReg   = mem_to_reg_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.ALUSrcA    = alu_src_a_s;
  assign bus.ALUSrcB    = alu_src_b_s;
  assign bus.SignExtend = sign_ext_s;
  assign bus.PCSource   = pc_source_s;
  assign bus.ALUOp      = alu_op_s;
  assign bus.Retire     = retire_s;
  assign bus.IllegalOp  = illegal_s;
  assign bus.InstrCount = count_q;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed cases plus random
// instruction streams with random memory wait states, compared against an
// instruction-level model (class -> latency, state sequence, event counts).
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_J = 5, C_ILL = 6;

  logic CLK = 1'b0;
  logic Reset_L = 1'b0;
  always #5 CLK = ~CLK;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int acc_waits[$];
  bit in_acc = 1'b0;
  int wl = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.PCEn, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.SignExtend, bus.PCSource, bus.ALUOp, bus.Retire,
                bus.IllegalOp, bus.InstrCount, bus.State});
  endfunction

  function automatic int classify(input logic [5:0] op);
    if (op == 6'd0) return C_R;
    if (op >= 6'd8 && op <= 6'd14) return C_I;
    if (op == 6'd35) return C_LD;
    if (op == 6'd43) return C_ST;
    if (op == 6'd4 || op == 6'd5) return C_BR;
    if (op == 6'd2) return C_J;
    return C_ILL;
  endfunction

  function automatic logic [63:0] push4(input logic [63:0] t, input int v);
    return {t[59:0], 4'(v)};
  endfunction

  // One cycle: memory answers the request it sees, then outputs are sampled
  // mid-cycle, well before the next rising edge.
  task automatic step();
    @(negedge CLK);
    #1;
    if (bus.MemRead || bus.MemWrite) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        wl = (acc_waits.size() > 0) ? acc_waits.pop_front() : 0;
      end
      if (wl > 0) begin
        bus.MemReady = 1'b0;
        wl--;
      end else begin
        bus.MemReady = 1'b1;
        in_acc = 1'b0;
      end
    end else begin
      bus.MemReady = 1'b1;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    Reset_L = 1'b1;
    #2;
    check_eq("idle_outs", all_outs(), 64'd0);
    exp_cnt = 0;
  endtask

  // Runs one instruction starting in FETCH and checks it against the model.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int cls, cyc, exp_cyc, base[7];
    bit done, exec_seen;
    int pcen_n, rw_n, m2r_n, mw_n, mr_n, ir_n, ill_n, ret_n, both_n;
    logic rd_seen, se_wb, se_ex;
    logic [3:0] exec_op, exp_op;
    logic [1:0] pcsrc_last;
    logic [63:0] tr, exp_tr;
    logic [3:0] itab[7];
    bit is_mem, exp_se;
    itab = '{4'b0111, 4'b0001, 4'b1010, 4'b1011, 4'b0100, 4'b0101, 4'b0110};
    base = '{4, 4, 5, 4, 3, 3, 2};
    cls = classify(op);
    is_mem = (cls == C_LD) || (cls == C_ST);
    exp_cyc = base[cls] + fw + (is_mem ? mw : 0);
    exp_tr = 64'd0;
    for (int i = 0; i <= fw; i++) exp_tr = push4(exp_tr, 1);
    exp_tr = push4(exp_tr, 2);
    case (cls)
      C_R:  begin exp_tr = push4(exp_tr, 7); exp_tr = push4(exp_tr, 8); end
      C_I:  begin exp_tr = push4(exp_tr, 9); exp_tr = push4(exp_tr, 10); end
      C_LD: begin
        exp_tr = push4(exp_tr, 3);
        for (int i = 0; i <= mw; i++) exp_tr = push4(exp_tr, 4);
        exp_tr = push4(exp_tr, 5);
      end
      C_ST: begin
        exp_tr = push4(exp_tr, 3);
        for (int i = 0; i <= mw; i++) exp_tr = push4(exp_tr, 6);
      end
      C_BR: exp_tr = push4(exp_tr, 11);
      C_J:  exp_tr = push4(exp_tr, 12);
      default: ;
    endcase
    acc_waits.push_back(fw);
    if (is_mem) acc_waits.push_back(mw);
    bus.Opcode = op;
    bus.Zero = z;
    cyc = 0; done = 1'b0; exec_seen = 1'b0; tr = 64'd0;
    pcen_n = 0; rw_n = 0; m2r_n = 0; mw_n = 0; mr_n = 0; ir_n = 0; ill_n = 0; ret_n = 0; both_n = 0;
    rd_seen = 1'b0; se_wb = 1'b0; se_ex = 1'b0; exec_op = 4'd0; pcsrc_last = 2'd0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
      tr = push4(tr, int'(bus.State));
      if (cyc == 1) begin
        check_eq("fetch_state", 64'(bus.State), 64'd1);
        check_eq("fetch_memread_iord", 64'({bus.MemRead, bus.IorD}), 64'b10);
      end
      pcen_n += int'(bus.PCEn);  rw_n += int'(bus.RegWrite); m2r_n += int'(bus.MemtoReg);
      mw_n += int'(bus.MemWrite); mr_n += int'(bus.MemRead); ir_n += int'(bus.IRWrite);
      ill_n += int'(bus.IllegalOp); ret_n += int'(bus.Retire);
      both_n += int'(bus.MemRead & bus.MemWrite);
      if (bus.RegWrite) begin rd_seen = bus.RegDst; se_wb = bus.SignExtend; end
      if (bus.ALUSrcA && !exec_seen) begin
        exec_seen = 1'b1; exec_op = bus.ALUOp; se_ex = bus.SignExtend;
      end
      if (bus.Retire) begin done = 1'b1; pcsrc_last = bus.PCSource; end
    end
    check_eq($sformatf("retire_seen op=%0h", op), 64'(done), 64'd1);
    check_eq($sformatf("cycles op=%0h", op), 64'(cyc), 64'(exp_cyc));
    check_eq($sformatf("trace op=%0h", op), tr, exp_tr);
    check_eq("pcen_count", 64'(pcen_n),
             64'(1 + (cls == C_J ? 1 : 0) + ((cls == C_BR && (z ^ op[0])) ? 1 : 0)));
    check_eq("regwrite_count", 64'(rw_n), 64'((cls == C_R || cls == C_I || cls == C_LD) ? 1 : 0));
    check_eq("memtoreg_count", 64'(m2r_n), 64'((cls == C_LD) ? 1 : 0));
    check_eq("memwrite_count", 64'(mw_n), 64'((cls == C_ST) ? 1 + mw : 0));
    check_eq("memread_count", 64'(mr_n), 64'(1 + fw + ((cls == C_LD) ? 1 + mw : 0)));
    check_eq("irwrite_count", 64'(ir_n), 64'd1);
    check_eq("illegal_count", 64'(ill_n), 64'((cls == C_ILL) ? 1 : 0));
    check_eq("retire_count", 64'(ret_n), 64'd1);
    check_eq("rd_wr_overlap", 64'(both_n), 64'd0);
    check_eq("exec_seen", 64'(exec_seen), 64'((cls == C_J || cls == C_ILL) ? 0 : 1));
    if (exec_seen) begin
      case (cls)
        C_R:  exp_op = 4'b1111;
        C_I:  exp_op = itab[op[2:0]];
        C_BR: exp_op = 4'b1000;
        default: exp_op = 4'b1110;
      endcase
      check_eq($sformatf("exec_aluop op=%0h", op), 64'(exec_op), 64'(exp_op));
    end
    exp_se = (cls == C_LD || cls == C_ST) || (cls == C_I && op <= 6'd11);
    if (exec_seen && cls != C_BR && cls != C_R)
      check_eq($sformatf("exec_signext op=%0h", op), 64'(se_ex), 64'(exp_se));
    if (rw_n > 0) begin
      check_eq("regdst", 64'(rd_seen), 64'((cls == C_R) ? 1 : 0));
      if (cls == C_I) check_eq("wb_signext", 64'(se_wb), 64'(exp_se));
    end
    if (cls == C_BR) check_eq("br_pcsource", 64'(pcsrc_last), 64'b01);
    if (cls == C_J)  check_eq("j_pcsource", 64'(pcsrc_last), 64'b10);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    @(posedge CLK);
    #1;
    check_eq("instr_count", 64'(bus.InstrCount), 64'(exp_cnt));
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] legal[13];
    int k;
    legal = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
    k = $urandom_range(0, 14);
    if (k < 13) return legal[k];
    return 6'($urandom_range(48, 63));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Opcode = 6'd0;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #2;
      check_eq("reset_outs", all_outs(), 64'd0);
    end
    release_reset();

    run_instr(6'b000000, 1'b0, 0, 0);
    run_instr(6'b100011, 1'b0, 2, 2);
    run_instr(6'b000100, 1'b1, 0, 0);
    run_instr(6'b000100, 1'b0, 0, 0);
    run_instr(6'b000101, 1'b0, 0, 0);
    run_instr(6'b000101, 1'b1, 1, 0);
    run_instr(6'b001100, 1'b0, 0, 0);
    run_instr(6'b001010, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(6'b000010, 1'b0, 0, 0);
    run_instr(6'b101011, 1'b0, 1, 3);

    for (int n = 0; n < 60; n++)
      run_instr(rand_op(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));

    // Abort a store that is stalled in its write phase.
    acc_waits.delete();
    acc_waits.push_back(0);
    acc_waits.push_back(10);
    bus.Opcode = 6'b101011;
    for (int i = 0; i < 4; i++) step();
    check_eq("mw_before_reset", 64'({bus.MemWrite, bus.State}), 64'({1'b1, 4'd6}));
    Reset_L = 1'b0;
    #1;
    check_eq("mw_async_drop", 64'(bus.MemWrite), 64'd0);
    check_eq("reset_mid_outs", all_outs(), 64'd0);
    acc_waits.delete();
    in_acc = 1'b0;
    wl = 0;
    @(posedge CLK);
    release_reset();
    run_instr(6'b001000, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
